counter_tick_gen: RTL and testbench

Programmable enable-strobe generator that sits directly upstream of the up-counter and drives its `enable` input. It divides `clk` by a loadable period and emits single-cycle strobes. Strobes run either free (continuous) or as a finite burst of N strobes, under a small valid/ready command interface from the control logic.

---
 rtl/counter_tick_gen_pkg.sv | 19 +
 rtl/counter_tick_gen_if.sv | 29 ++
 rtl/counter_tick_gen_prescaler.sv | 26 ++
 rtl/counter_tick_gen.sv | 132 +++++++++++++
 tb/tb_counter_tick_gen.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/counter_tick_gen_pkg.sv
// Shared op-codes, FSM state encoding and width helper for the tick generator.
package counter_tick_pkg;

    localparam logic [1:0] OP_STOP  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_BURST = 2'd2;
    localparam logic [1:0] OP_LOAD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/counter_tick_gen_if.sv
// Command (valid/ready) and strobe/status bundle between control logic and the tick generator.
interface counter_tick_gen_if
    import counter_tick_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 16
);
    localparam int DATA_W = max_w(DIV_WIDTH, CNT_WIDTH);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              enable;
    logic              busy;
    logic              done;
    logic              cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, enable, busy, done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, enable, busy, done, cmd_err
    );

endinterface

// File: rtl/counter_tick_gen_prescaler.sv
// Prescale counter: counts 0..div while running and flags the cycle where it wraps.
module tick_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] div,
    input  logic         run,
    input  logic         clear,
    output logic         tick
);

    logic [W-1:0] r_pcnt;

    assign tick = run && (r_pcnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pcnt <= '0;
        else if (clear || !run || tick)
            r_pcnt <= '0;
        else
            r_pcnt <= r_pcnt + W'(1);
    end

endmodule

// File: rtl/counter_tick_gen.sv
// Programmable enable-strobe generator: free-running or N-strobe bursts at period div+1.
module counter_tick_gen
    import counter_tick_pkg::*;
#(
    parameter int                   DIV_WIDTH = 16,
    parameter int                   CNT_WIDTH = 16,
    parameter logic [DIV_WIDTH-1:0] DIV_INIT  = '0
) (
    input  logic               clk,
    input  logic               rst,
    counter_tick_gen_if.slave  bus
);

    state_t               r_state, w_state_nx;
    logic [DIV_WIDTH-1:0] r_div, w_div_nx;
    logic [CNT_WIDTH-1:0] r_rem, w_rem_nx;
    logic                 r_enable, w_enable_nx;
    logic                 r_busy;
    logic                 r_done, w_done_nx;
    logic                 r_err, w_err_nx;
    logic                 w_clear, w_tick;
    logic [CNT_WIDTH-1:0] w_cmd_n;
    logic [DIV_WIDTH-1:0] w_cmd_div;

    assign w_cmd_n   = bus.cmd_data[CNT_WIDTH-1:0];
    assign w_cmd_div = bus.cmd_data[DIV_WIDTH-1:0];

    tick_prescaler #(.W(DIV_WIDTH)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .div   (r_div),
        .run   (r_state != ST_IDLE),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_div_nx    = r_div;
        w_rem_nx    = r_rem;
        w_enable_nx = 1'b0;
        w_done_nx   = 1'b0;
        w_err_nx    = 1'b0;
        w_clear     = 1'b0;

        if (w_tick) begin
            w_enable_nx = 1'b1;
            if (r_state == ST_BURST) begin
                w_rem_nx = r_rem - CNT_WIDTH'(1);
                if (r_rem == CNT_WIDTH'(1)) begin
                    w_state_nx = ST_IDLE;
                    w_done_nx  = 1'b1;
                end
            end
        end

        // Commands override tick results; STOP also kills a coincident strobe.
        if (bus.cmd_valid) begin
            case (r_state)
                ST_IDLE: begin
                    case (bus.cmd_op)
                        OP_RUN: begin
                            w_state_nx = ST_RUN;
                            w_clear    = 1'b1;
                        end
                        OP_BURST: if (w_cmd_n != '0) begin
                            w_state_nx = ST_BURST;
                            w_rem_nx   = w_cmd_n;
                            w_clear    = 1'b1;
                        end
                        OP_LOAD: w_div_nx = w_cmd_div;
                        default: ;
                    endcase
                end
                ST_RUN: begin
                    case (bus.cmd_op)
                        OP_STOP: begin
                            w_state_nx  = ST_IDLE;
                            w_clear     = 1'b1;
                            w_enable_nx = 1'b0;
                        end
                        OP_RUN:  w_clear = 1'b1;
                        OP_LOAD: begin
                            w_div_nx = w_cmd_div;
                            w_clear  = 1'b1;
                        end
                        default: w_err_nx = 1'b1;
                    endcase
                end
                ST_BURST: begin
                    if (bus.cmd_op == OP_STOP) begin
                        w_state_nx  = ST_IDLE;
                        w_rem_nx    = '0;
                        w_clear     = 1'b1;
                        w_enable_nx = 1'b0;
                        w_done_nx   = 1'b0;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_div    <= DIV_INIT;
            r_rem    <= '0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_div    <= w_div_nx;
            r_rem    <= w_rem_nx;
            r_enable <= w_enable_nx;
            r_busy   <= (w_state_nx != ST_IDLE);
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
        end
    end

    assign bus.cmd_ready = 1'b1;
    assign bus.enable    = r_enable;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cmd_err   = r_err;

endmodule

// File: tb/tb_counter_tick_gen.sv
// Directed bench for counter_tick_gen: per-edge expectations queued then checked after the edge.
module tb_counter_tick_gen;
    import counter_tick_pkg::*;

    typedef struct {
        logic [3:0] v;   // {enable, busy, done, cmd_err}
        string      tag;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    counter_tick_gen_if #(.DIV_WIDTH(16), .CNT_WIDTH(16)) bus ();

    counter_tick_gen #(.DIV_WIDTH(16), .CNT_WIDTH(16), .DIV_INIT(16'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_now(input logic [3:0] exp, input string tag);
        logic [3:0] obs;
        obs = {bus.enable, bus.busy, bus.done, bus.cmd_err};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed en/busy/done/err=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [15:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
    endtask

    task automatic step(input logic en, input logic b, input logic d, input logic e,
                        input string tag);
        exp_t x;
        exp_q.push_back('{v: {en, b, d, e}, tag: tag});
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check_now(x.v, x.tag);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_STOP;
        bus.cmd_data  = '0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_STOP;
        bus.cmd_data  = '0;
        #2;
        check_now(4'b0000, "reset_outputs");
        checks++;
        assert (bus.cmd_ready === 1'b1) else begin
            errors++;
            $error("FAIL cmd_ready: observed=%b expected=1", bus.cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, "idle_after_reset");

        // RUN with div=0: continuous enable, then STOP
        cmd(OP_RUN, 16'd0);
        step(0, 1, 0, 0, "run0_accept");
        for (int k = 1; k <= 4; k++) step(1, 1, 0, 0, "run0_strobe");
        cmd(OP_STOP, 16'd0);
        step(0, 0, 0, 0, "run0_stop");
        step(0, 0, 0, 0, "run0_stopped");

        // LOAD 3, BURST 4: strobes at +4,+8,+12,+16, done with the last
        cmd(OP_LOAD, 16'd3);
        step(0, 0, 0, 0, "load3");
        cmd(OP_BURST, 16'd4);
        step(0, 1, 0, 0, "burst4_accept");
        for (int k = 1; k <= 16; k++)
            step((k % 4) == 0, k < 16, k == 16, 0, "burst4");
        step(0, 0, 0, 0, "burst4_after");

        // RUN at div=9, LOAD 2 while pcnt=7: next strobe 3 cycles later
        cmd(OP_LOAD, 16'd9);
        step(0, 0, 0, 0, "load9");
        cmd(OP_RUN, 16'd0);
        step(0, 1, 0, 0, "run9_accept");
        for (int k = 1; k <= 7; k++) step(0, 1, 0, 0, "run9_count");
        cmd(OP_LOAD, 16'd2);
        step(0, 1, 0, 0, "run_load2");
        for (int k = 1; k <= 9; k++) step((k % 3) == 0, 1, 0, 0, "run_div2");
        cmd(OP_STOP, 16'd0);
        step(0, 0, 0, 0, "run_div2_stop");

        // BURST 5 at div=1 with a dropped RUN mid-burst
        cmd(OP_LOAD, 16'd1);
        step(0, 0, 0, 0, "load1");
        cmd(OP_BURST, 16'd5);
        step(0, 1, 0, 0, "burst5_accept");
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) cmd(OP_RUN, 16'd0);
            step((k % 2) == 0, k < 10, k == 10, k == 3, "burst5_err");
        end
        step(0, 0, 0, 0, "burst5_after");

        // BURST 5 with STOP on a would-be strobe edge
        cmd(OP_BURST, 16'd5);
        step(0, 1, 0, 0, "burst5s_accept");
        for (int k = 1; k <= 3; k++) step((k % 2) == 0, 1, 0, 0, "burst5s");
        cmd(OP_STOP, 16'd0);
        step(0, 0, 0, 0, "burst5s_stop");
        for (int k = 1; k <= 4; k++) step(0, 0, 0, 0, "burst5s_quiet");

        // BURST 0 is a no-op
        cmd(OP_BURST, 16'd0);
        step(0, 0, 0, 0, "burst0");
        for (int k = 1; k <= 3; k++) step(0, 0, 0, 0, "burst0_quiet");

        // Async reset mid-RUN while enable is high
        cmd(OP_RUN, 16'd0);
        step(0, 1, 0, 0, "rst_run_accept");
        step(0, 1, 0, 0, "rst_run_k1");
        step(1, 1, 0, 0, "rst_run_k2");
        #3;
        rst = 1'b1;
        #1;
        check_now(4'b0000, "async_reset");
        #2;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) step(0, 0, 0, 0, "post_rst_idle");
        // div back to DIV_INIT=0: enable every cycle
        cmd(OP_RUN, 16'd0);
        step(0, 1, 0, 0, "post_rst_run");
        step(1, 1, 0, 0, "post_rst_div0_a");
        step(1, 1, 0, 0, "post_rst_div0_b");
        cmd(OP_STOP, 16'd0);
        step(0, 0, 0, 0, "post_rst_stop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
